// File: rtl/cnt_sched_pkg.sv
// Shared definitions for the round-robin event-counter scheduler.
package cnt_sched_pkg;

  localparam int unsigned LENW_DEFAULT = 4;
  localparam int unsigned LEN_BUS_W    = 256;
  localparam int unsigned LEN_MAX_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Field idx of width w from a zero-extended packed length bus; upper bits come back zero.
  function automatic logic [LEN_MAX_W-1:0] len_field(input logic [LEN_BUS_W-1:0] lens,
                                                      input int unsigned idx,
                                                      input int unsigned w);
    logic [LEN_BUS_W-1:0] sh;
    logic [LEN_MAX_W-1:0] mask;
    sh   = lens >> (idx * w);
    mask = LEN_MAX_W'((17'(1) << w) - 17'(1));
    return sh[LEN_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/cnt_sched_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic                    vld
);

  int d, best_d, best_i;

  always_comb begin
    d      = 0;
    best_d = NREQ;
    best_i = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        // circular distance from the slot just after the last winner
        d = (i - int'(ptr) - 1 + 2 * NREQ) % NREQ;
        if (d < best_d) begin
          best_d = d;
          best_i = i;
        end
      end
    end
    gnt = '0;
    for (int i = 0; i < NREQ; i++)
      if (best_d < NREQ && i == best_i) gnt[i] = 1'b1;
  end

  assign vld = |req;

endmodule

// File: rtl/cnt_sched.sv
// Grants one requester at a time a burst of counter increments on its chosen channel.
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LENW = LENW_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ-1:0]      ReqSlt,
  input  logic [NREQ*LENW-1:0] ReqLen,
  input  logic                 Clr,
  output logic [NREQ-1:0]      Gnt,
  output logic [NREQ-1:0]      Done,
  output logic                 Busy,
  output logic                 CntEn,
  output logic                 CntSlt,
  output logic                 CntClr,
  output logic [LENW-1:0]      BeatCnt
);

  localparam int PW = $clog2(NREQ);

  state_e                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d, win_q, win_d;
  logic                   slt_q, slt_d;
  logic [NREQ-1:0]        gnt_q, gnt_d, done_q, done_d;
  logic                   busy_q, busy_d, cnt_en_q, cnt_en_d;
  logic                   cnt_slt_q, cnt_slt_d, cnt_clr_q, cnt_clr_d;
  logic [LENW-1:0]        beat_q, beat_d;

  logic [NREQ-1:0]        pick_gnt;
  logic                   pick_vld, pick_slt;
  logic [PW-1:0]          pick_idx;
  logic [LEN_BUS_W-1:0]   len_bus;
  logic [LEN_MAX_W-1:0]   pick_len;
  logic [NREQ-1:0]        win_oh;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (Req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .vld (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick_gnt[i]) pick_idx = PW'(i);
    len_bus = '0;
    len_bus[NREQ*LENW-1:0] = ReqLen;
    pick_len = len_field(len_bus, 32'(pick_idx), 32'(LENW));
    pick_slt = |(ReqSlt & pick_gnt);
    win_oh   = NREQ'(1) << win_q;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    slt_d     = slt_q;
    gnt_d     = '0;
    done_d    = '0;
    cnt_en_d  = 1'b0;
    cnt_slt_d = 1'b0;
    cnt_clr_d = 1'b0;
    beat_d    = '0;
    case (state_q)
      IDLE: begin
        if (Clr) begin
          cnt_clr_d = 1'b1;
        end else if (pick_vld) begin
          win_d = pick_idx;
          slt_d = pick_slt;
          if (pick_len != '0) begin
            state_d   = RUN;
            gnt_d     = pick_gnt;
            cnt_en_d  = 1'b1;
            cnt_slt_d = pick_slt;
            beat_d    = pick_len[LENW-1:0];
          end else begin
            state_d = DONE;
            done_d  = pick_gnt;
          end
        end
      end
      RUN: begin
        if (beat_q == LENW'(1)) begin
          state_d = DONE;
          done_d  = win_oh;
        end else begin
          gnt_d     = win_oh;
          cnt_en_d  = 1'b1;
          cnt_slt_d = slt_q;
          beat_d    = beat_q - LENW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = win_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      ptr_q     <= PW'(NREQ - 1);
      win_q     <= '0;
      slt_q     <= 1'b0;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      cnt_en_q  <= 1'b0;
      cnt_slt_q <= 1'b0;
      cnt_clr_q <= 1'b0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      slt_q     <= slt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cnt_en_q  <= cnt_en_d;
      cnt_slt_q <= cnt_slt_d;
      cnt_clr_q <= cnt_clr_d;
      beat_q    <= beat_d;
    end
  end

  assign Gnt     = gnt_q;
  assign Done    = done_q;
  assign Busy    = busy_q;
  assign CntEn   = cnt_en_q;
  assign CntSlt  = cnt_slt_q;
  assign CntClr  = cnt_clr_q;
  assign BeatCnt = beat_q;

endmodule

// File: tb/tb_cnt_sched.sv
// Scoreboard bench: a transaction model predicts each clear/burst and its exact cycle window.
module tb_cnt_sched;

  localparam int NREQ = 4;
  localparam int LENW = 4;
  localparam int OW   = 2 * NREQ + 4 + LENW;

  logic                 clk = 1'b0;
  logic                 Reset = 1'b1;
  logic [NREQ-1:0]      Req = '0, ReqSlt = '0;
  logic [NREQ*LENW-1:0] ReqLen = '0;
  logic                 Clr = 1'b0;
  logic [NREQ-1:0]      Gnt, Done;
  logic                 Busy, CntEn, CntSlt, CntClr;
  logic [LENW-1:0]      BeatCnt;

  always #5 clk = ~clk;

  cnt_sched #(.NREQ(NREQ), .LENW(LENW)) dut (
    .Clk(clk), .Reset(Reset), .Req(Req), .ReqSlt(ReqSlt), .ReqLen(ReqLen), .Clr(Clr),
    .Gnt(Gnt), .Done(Done), .Busy(Busy), .CntEn(CntEn), .CntSlt(CntSlt),
    .CntClr(CntClr), .BeatCnt(BeatCnt)
  );

  typedef struct {
    bit clr;
    int w;
    int len;
    bit slt;
    int due;   // edge after which Done (or CntClr) is visible
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   vectors = 0, miscompares = 0;
  int   en_count = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Reference model: idle whenever the last transaction's window has closed.
  initial begin
    int ptr_m, free_m, w, len;
    logic [NREQ*LENW-1:0] sh;
    ptr_m = NREQ - 1;
    free_m = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (Reset) begin
        sbq.delete();
        ptr_m  = NREQ - 1;
        free_m = cyc + 1;
      end else if (cyc >= free_m) begin
        if (Clr) begin
          sbq.push_back('{clr: 1'b1, w: 0, len: 0, slt: 1'b0, due: cyc});
          free_m = cyc + 1;
        end else if (Req != '0) begin
          w = -1;
          for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (ptr_m + k) % NREQ;
            if (w < 0 && Req[i]) w = i;
          end
          sh  = ReqLen >> (LENW * w);
          len = int'(sh[LENW-1:0]);
          sbq.push_back('{clr: 1'b0, w: w, len: len, slt: ReqSlt[w], due: cyc + len});
          free_m = cyc + len + 2;
          ptr_m  = w;
        end
      end
    end
  end

  // Monitor: full output vector checked every cycle against the head transaction.
  initial begin
    exp_t e;
    logic [NREQ-1:0] e_gnt, e_done;
    logic e_busy, e_en, e_slt, e_clr;
    logic [LENW-1:0] e_beat;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        e_gnt = '0; e_done = '0; e_busy = 0; e_en = 0; e_slt = 0; e_clr = 0; e_beat = '0;
        if (sbq.size() > 0) begin
          e = sbq[0];
          if (e.clr) begin
            if (cyc == e.due) e_clr = 1'b1;
          end else if (cyc >= e.due - e.len && cyc < e.due) begin
            e_gnt  = NREQ'(1) << e.w;
            e_en   = 1'b1;
            e_slt  = e.slt;
            e_beat = LENW'(e.due - cyc);
            e_busy = 1'b1;
          end else if (cyc == e.due) begin
            e_done = NREQ'(1) << e.w;
            e_busy = 1'b1;
          end
        end
        check("outputs", 64'({Gnt, Done, Busy, CntEn, CntSlt, CntClr, BeatCnt}),
              64'(OW'({e_gnt, e_done, e_busy, e_en, e_slt, e_clr, e_beat})));
        if (CntEn) en_count++;
        if (sbq.size() > 0 && cyc >= sbq[0].due) void'(sbq.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    check(name, 64'({Gnt, Done, Busy, CntEn, CntSlt, CntClr, BeatCnt}), 64'(0));
  endtask

  initial begin
    int en0;
    tick(2);
    check_idle("reset_state");
    Reset = 1'b0;
    tick(1);

    // single length-3 burst on channel 0
    ReqLen = 16'h0003; ReqSlt = 4'b0000; Req = 4'b0001;
    tick(1); Req = '0; tick(6);

    // all requesting, length 1: rotating grants
    ReqLen = 16'h1111; Req = 4'b1111;
    tick(15); Req = '0; tick(6);

    // zero-length request
    ReqLen = 16'h0000; Req = 4'b0100;
    tick(1); Req = '0; tick(3);

    // clear takes priority over a pending request
    ReqLen = 16'h0020; Clr = 1'b1; Req = 4'b0010;
    tick(1); Clr = 1'b0; tick(1); Req = '0; tick(5);

    // reset mid-burst, then requester 0 wins first
    ReqLen = 16'h5000; Req = 4'b1000;
    tick(1); Req = '0; tick(1);
    Reset = 1'b1; tick(1); Reset = 1'b0;
    check_idle("reset_abort");
    check("sbq_flushed", 64'(sbq.size()), 64'(0));
    ReqLen = 16'h2002; Req = 4'b1001;
    tick(1); Req = 4'b1000; tick(4); Req = '0; tick(8);

    // max-length burst on channel 1, inputs disturbed mid-burst
    en0 = en_count;
    ReqLen = 16'h00F0; ReqSlt = 4'b0010; Req = 4'b0010;
    tick(1); Req = '0; tick(3);
    ReqLen = 16'h0010; ReqSlt = 4'b0000; Clr = 1'b1;
    tick(2); Clr = 1'b0; tick(20);
    check("len15_en_cycles", 64'(en_count - en0), 64'(15));

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      Req    = NREQ'($urandom) & NREQ'($urandom);
      ReqSlt = NREQ'($urandom);
      ReqLen = (NREQ*LENW)'($urandom);
      Clr    = ($urandom_range(15) == 0);
      Reset  = ($urandom_range(199) == 0);
      tick(1);
    end
    Req = '0; Clr = 1'b0; Reset = 1'b0;
    tick(25);
    check("sbq_drained", 64'(sbq.size()), 64'(0));
    check_idle("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cnt_sched.md
Name: cnt_sched

Overview:
- Round-robin scheduler that shares one dual-channel event counter among NREQ requesters.
- Counter interface:
  - En/Slt: Slt=0 increments channel 0 directly; Slt=1 increments channel 1 through a /4 prescale.
  - Clear: a separate clear strobe.
- Each requester asks for a burst of 0–15 increments on one channel. The scheduler grants one requester at a time, drives the counter controls for exactly that many cycles, then signals completion.
- Clear requests are serviced with priority when the scheduler is idle.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LENW, 4, burst-length field width; maximum burst is 2^LENW-1.

Ports:
- Clk  input  1  system clock, all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  NREQ  per-requester request level.
- ReqSlt  input  NREQ  per-requester channel select (0 = channel 0, 1 = channel 1).
- ReqLen  input  NREQ*LENW  packed burst lengths; requester i uses [LENW*i+LENW-1 : LENW*i].
- Clr  input  1  counter-clear request level.
- Gnt  output  NREQ  one-hot grant, high only in RUN.
- Done  output  NREQ  one-hot completion pulse, one cycle.
- Busy  output  1  high in RUN or DONE.
- CntEn  output  1  counter enable.
- CntSlt  output  1  counter channel select.
- CntClr  output  1  counter clear strobe, one cycle.
- BeatCnt  output  LENW  beats remaining, including the current one.

Behaviour:
- All outputs registered. No combinational path from inputs to outputs.
- Reset (sampled at a rising edge):
  - Next cycle all outputs are 0 and state is IDLE.
  - Latched length, channel and winner are cleared.
  - RR pointer is set to NREQ-1, so requester 0 has first priority.
  - Reset mid-RUN aborts the burst with no Done pulse.
- States are IDLE, RUN and DONE.
- IDLE, checked in this order:
  - Clr=1: CntClr=1 in the next cycle and state stays IDLE. Any pending Req is arbitrated one cycle later.
  - Any Req bit set: pick the winner as the first set bit searching upward, circularly, from ptr+1. Latch the winner, ReqSlt[w] and ReqLen[w].
  - Len>0: go to RUN.
  - Len=0: go directly to DONE. CntEn is never asserted.
- RUN, Len cycles:
  - Gnt[w]=1, CntEn=1, CntSlt=latched slt.
  - BeatCnt counts Len, Len-1, …, 1.
  - On the BeatCnt=1 cycle, go to DONE.
  - Changes on Req, ReqSlt, ReqLen or Clr during RUN are ignored. The burst always completes.
- DONE, one cycle:
  - Done[w]=1, Gnt=0, CntEn=0, BeatCnt=0.
  - ptr is set to w, then state returns to IDLE.
- Timing for a request sampled in IDLE at cycle t with length L≥1:
  - Gnt and CntEn are high for cycles t+1..t+L.
  - Done is high at t+L+1.
  - Earliest next grant is at t+L+3.
- Clr is a level input: it is only sampled in IDLE. The requester holds it until CntClr is seen; Clr held continuously starves Req.
- A requester must drop Req in its Done cycle or it re-requests. Fairness comes from the pointer, so a held Req waits behind the other active requesters.
- CntEn and CntClr are never high in the same cycle. Busy = state is RUN or DONE.

Decomposition:
- Package cnt_sched_pkg holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default LENW;
  - a function to extract the length field.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], ptr.
  - Outputs: one-hot grant and valid.
  - Unit-tested separately.

Test Plan:
- Reset; Req=0001, ReqLen[0]=3, ReqSlt[0]=0 sampled at cycle 1 → Gnt=0001 and CntEn=1, CntSlt=0 in cycles 2–4; BeatCnt 3, 2, 1; Done=0001 at cycle 5; Busy high in cycles 2–5.
- Req=1111 held with all lengths 1 → grants in order 0, 1, 2, 3, 0, spaced 3 cycles apart; exactly one CntEn cycle per grant.
- Req[2] with ReqLen[2]=0 → Done=0100 the cycle after sampling; CntEn never high; Gnt stays 0.
- Clr and Req[1] (length 2) both high in IDLE at cycle t → CntClr=1 at t+1 with Gnt=0; Gnt=0010 at t+2..t+3; Done at t+4.
- Req[3] with length 5; Reset asserted after the 2nd RUN cycle → next cycle all outputs 0 and no Done. Then Req=1001 → Gnt=0001 first.
- Req[1] with length 15 and ReqSlt[1]=1 → CntSlt=1 and CntEn=1 for exactly 15 cycles; BeatCnt 15 down to 1. Changing ReqLen/ReqSlt mid-burst has no effect.
